// File: rtl/zx81_kbd_pkg.sv
// Shared definitions for the ZX81 keyboard matrix.
// Holds the state-vector layout, the scancodes with special meaning, and the
// compound-key table. Compound keys are PC keys that the ZX81 produces as
// SHIFT plus a base key.
package zx81_kbd_pkg;

    localparam int unsigned NUM_ROWS = 8;
    localparam int unsigned NUM_COLS = 5;
    localparam int unsigned NUM_PHYS = NUM_ROWS * NUM_COLS;   // 40 matrix positions
    localparam int unsigned NUM_CMP  = 6;
    localparam int unsigned NUM_KEYS = NUM_PHYS + 2 + NUM_CMP; // 48 state bits

    // Layout of the key-state and pending-release vectors.
    // Bits 0..39 are row*5+col. Bit 0 (SHIFT) is never set directly, because
    // the shift keys use their own bits.
    localparam int unsigned IDX_SHIFT_L = NUM_PHYS;
    localparam int unsigned IDX_SHIFT_R = NUM_PHYS + 1;
    localparam int unsigned IDX_CMP0    = NUM_PHYS + 2;

    localparam int unsigned ROW_SHIFT = 0;
    localparam int unsigned COL_SHIFT = 0;

    localparam logic [7:0] SC_SHIFT_L = 8'h12;
    localparam logic [7:0] SC_SHIFT_R = 8'h59;
    localparam logic [7:0] SC_F12     = 8'h07;
    localparam logic [7:0] SC_BKSP    = 8'h66;
    localparam logic [7:0] SC_COMMA   = 8'h41;
    localparam logic [7:0] SC_LEFT    = 8'h6B;
    localparam logic [7:0] SC_DOWN    = 8'h72;
    localparam logic [7:0] SC_UP      = 8'h75;
    localparam logic [7:0] SC_RIGHT   = 8'h74;

    typedef struct packed {
        logic [7:0] code;
        logic       e0;
        logic [2:0] row;
        logic [2:0] col;
    } cmp_entry_t;

    // Each compound key maps to SHIFT plus the base key at (row, col).
    localparam cmp_entry_t CMP_TABLE [NUM_CMP] = '{
        '{SC_BKSP,  1'b0, 3'd4, 3'd0},  // Backspace -> SHIFT+0
        '{SC_COMMA, 1'b0, 3'd7, 3'd1},  // comma     -> SHIFT+.
        '{SC_LEFT,  1'b1, 3'd3, 3'd4},  // left      -> SHIFT+5
        '{SC_DOWN,  1'b1, 3'd4, 3'd4},  // down      -> SHIFT+6
        '{SC_UP,    1'b1, 3'd4, 3'd3},  // up        -> SHIFT+7
        '{SC_RIGHT, 1'b1, 3'd4, 3'd2}   // right     -> SHIFT+8
    };

endpackage

// File: rtl/zx81_scancode_decode.sv
// Combinational decoder from a PS/2 scancode ({E0, code}) to a ZX81 key.
// Ports:
//   e0          in   E0 extended-prefix flag
//   code        in   8-bit scancode
//   valid       out  code is a key this block cares about
//   is_shift_l  out  left SHIFT
//   is_shift_r  out  right SHIFT
//   is_compound out  compound key; cmp_idx selects its CMP_TABLE entry
//   cmp_idx     out  compound table index
//   row, col    out  matrix position (physical key, or compound base key)
//   is_f12      out  F12, used as the reset request
module zx81_scancode_decode (
    input  logic       e0,
    input  logic [7:0] code,
    output logic       valid,
    output logic       is_shift_l,
    output logic       is_shift_r,
    output logic       is_compound,
    output logic [2:0] cmp_idx,
    output logic [2:0] row,
    output logic [2:0] col,
    output logic       is_f12
);
    import zx81_kbd_pkg::*;

    // {hit, row, col}, written as octal 1_r_c.
    logic [6:0] phys;

    always_comb begin
        unique case (code)
            8'h1A: phys = 7'o101;  // Z
            8'h22: phys = 7'o102;  // X
            8'h21: phys = 7'o103;  // C
            8'h2A: phys = 7'o104;  // V
            8'h1C: phys = 7'o110;  // A
            8'h1B: phys = 7'o111;  // S
            8'h23: phys = 7'o112;  // D
            8'h2B: phys = 7'o113;  // F
            8'h34: phys = 7'o114;  // G
            8'h15: phys = 7'o120;  // Q
            8'h1D: phys = 7'o121;  // W
            8'h24: phys = 7'o122;  // E
            8'h2D: phys = 7'o123;  // R
            8'h2C: phys = 7'o124;  // T
            8'h16: phys = 7'o130;  // 1
            8'h1E: phys = 7'o131;  // 2
            8'h26: phys = 7'o132;  // 3
            8'h25: phys = 7'o133;  // 4
            8'h2E: phys = 7'o134;  // 5
            8'h45: phys = 7'o140;  // 0
            8'h46: phys = 7'o141;  // 9
            8'h3E: phys = 7'o142;  // 8
            8'h3D: phys = 7'o143;  // 7
            8'h36: phys = 7'o144;  // 6
            8'h4D: phys = 7'o150;  // P
            8'h44: phys = 7'o151;  // O
            8'h43: phys = 7'o152;  // I
            8'h3C: phys = 7'o153;  // U
            8'h35: phys = 7'o154;  // Y
            8'h5A: phys = 7'o160;  // ENTER
            8'h4B: phys = 7'o161;  // L
            8'h42: phys = 7'o162;  // K
            8'h3B: phys = 7'o163;  // J
            8'h33: phys = 7'o164;  // H
            8'h29: phys = 7'o170;  // SPACE
            8'h49: phys = 7'o171;  // .
            8'h3A: phys = 7'o172;  // M
            8'h31: phys = 7'o173;  // N
            8'h32: phys = 7'o174;  // B
            default: phys = 7'o000;
        endcase
    end

    always_comb begin
        valid       = 1'b0;
        is_shift_l  = 1'b0;
        is_shift_r  = 1'b0;
        is_compound = 1'b0;
        cmp_idx     = 3'd0;
        row         = 3'd0;
        col         = 3'd0;
        is_f12      = 1'b0;

        if (!e0) begin
            if (phys[6]) begin
                valid = 1'b1;
                row   = phys[5:3];
                col   = phys[2:0];
            end else if (code == SC_SHIFT_L) begin
                valid      = 1'b1;
                is_shift_l = 1'b1;
            end else if (code == SC_SHIFT_R) begin
                valid      = 1'b1;
                is_shift_r = 1'b1;
            end else if (code == SC_F12) begin
                valid  = 1'b1;
                is_f12 = 1'b1;
            end
        end

        // E0 forms of physical codes fall through to here and stay invalid
        // unless they match a compound entry.
        for (int i = 0; i < int'(NUM_CMP); i++) begin
            if (e0 == CMP_TABLE[i].e0 && code == CMP_TABLE[i].code) begin
                valid       = 1'b1;
                is_compound = 1'b1;
                cmp_idx     = 3'(i);
                row         = CMP_TABLE[i].row;
                col         = CMP_TABLE[i].col;
            end
        end
    end

endmodule

// File: rtl/zx81_keymatrix.sv
// Converts PS/2 key events into the ZX81 8x5 keyboard matrix, as read by the
// ULA during port-FE IN cycles.
// Ports:
//   clk_sys   in   system clock
//   reset_n   in   asynchronous active-low reset
//   ps2_key   in   [10] event toggle, [9] make, [8] E0, [7:0] scancode
//   addr_hi   in   A15..A8, active-low row selects
//   kb_col    out  active-low column data, ANDed over the selected rows
//   key_reset out  high while F12 is held
// Short presses are held for at least MIN_HOLD cycles. A break that arrives
// while the hold timer runs is parked in a pending mask. All parked breaks
// are applied together when the timer expires.
module zx81_keymatrix #(
    parameter int unsigned MIN_HOLD = 500000,
    parameter int unsigned TW       = 19
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic [10:0] ps2_key,
    input  logic [7:0]  addr_hi,
    output logic [4:0]  kb_col,
    output logic        key_reset
);
    import zx81_kbd_pkg::*;

    logic                prev_q, primed_q, evt_q;
    logic [9:0]          ev_q;
    logic [NUM_KEYS-1:0] keys_q, keys_d, pend_q, pend_d;
    logic [TW-1:0]       timer_q, timer_d;
    logic                key_reset_q, key_reset_d;

    logic       dec_valid, dec_shift_l, dec_shift_r, dec_compound, dec_f12;
    logic [2:0] dec_cmp_idx, dec_row, dec_col;
    logic [5:0] key_idx;
    logic       is_make, expire;

    assign is_make = ev_q[9];

    zx81_scancode_decode u_decode (
        .e0          (ev_q[8]),
        .code        (ev_q[7:0]),
        .valid       (dec_valid),
        .is_shift_l  (dec_shift_l),
        .is_shift_r  (dec_shift_r),
        .is_compound (dec_compound),
        .cmp_idx     (dec_cmp_idx),
        .row         (dec_row),
        .col         (dec_col),
        .is_f12      (dec_f12)
    );

    always_comb begin
        key_idx = {3'b000, dec_row} * 6'd5 + {3'b000, dec_col};
        if (dec_shift_l) begin
            key_idx = 6'(IDX_SHIFT_L);
        end else if (dec_shift_r) begin
            key_idx = 6'(IDX_SHIFT_R);
        end else if (dec_compound) begin
            key_idx = 6'(IDX_CMP0) + {3'b000, dec_cmp_idx};
        end
    end

    always_comb begin
        keys_d      = keys_q;
        pend_d      = pend_q;
        timer_d     = timer_q;
        key_reset_d = key_reset_q;
        expire      = (timer_q == TW'(1));

        if (timer_q != '0) begin
            timer_d = timer_q - 1'b1;
        end
        if (expire) begin
            keys_d = keys_q & ~pend_q;
            pend_d = '0;
        end

        // Events are applied after the expiry clear, so a make in the expiry
        // cycle keeps its own key down.
        if (evt_q && dec_valid) begin
            if (dec_f12) begin
                key_reset_d = is_make;
            end else if (is_make) begin
                keys_d[key_idx] = 1'b1;
                pend_d[key_idx] = 1'b0;
                timer_d         = TW'(MIN_HOLD);
            end else if (timer_q == '0 || expire) begin
                // A break in the expiry cycle is applied at once. If it were
                // parked, it would be left behind by a timer that has stopped.
                keys_d[key_idx] = 1'b0;
                pend_d[key_idx] = 1'b0;
            end else begin
                pend_d[key_idx] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            prev_q      <= 1'b0;
            primed_q    <= 1'b0;
            evt_q       <= 1'b0;
            ev_q        <= '0;
            keys_q      <= '0;
            pend_q      <= '0;
            timer_q     <= '0;
            key_reset_q <= 1'b0;
        end else begin
            // The first cycle after reset only learns the toggle level.
            prev_q      <= ps2_key[10];
            primed_q    <= 1'b1;
            evt_q       <= primed_q && (ps2_key[10] != prev_q);
            ev_q        <= ps2_key[9:0];
            keys_q      <= keys_d;
            pend_q      <= pend_d;
            timer_q     <= timer_d;
            key_reset_q <= key_reset_d;
        end
    end

    assign key_reset = key_reset_q;

    logic [2:0]          vshift;
    logic [NUM_PHYS-1:0] down;

    always_comb begin
        vshift = 3'd0;
        for (int i = 0; i < int'(NUM_CMP); i++) begin
            vshift = vshift + {2'b00, keys_q[int'(IDX_CMP0) + i]};
        end

        down = keys_q[NUM_PHYS-1:0];
        down[ROW_SHIFT * NUM_COLS + COL_SHIFT] = keys_q[IDX_SHIFT_L] | keys_q[IDX_SHIFT_R] |
                                                 (vshift != 3'd0);
        for (int i = 0; i < int'(NUM_CMP); i++) begin
            down[int'(CMP_TABLE[i].row) * int'(NUM_COLS) + int'(CMP_TABLE[i].col)] |=
                keys_q[int'(IDX_CMP0) + i];
        end
    end

    always_comb begin
        kb_col = 5'h1F;
        for (int r = 0; r < int'(NUM_ROWS); r++) begin
            if (!addr_hi[r]) begin
                kb_col = kb_col & ~down[r*5 +: 5];
            end
        end
    end

endmodule

// File: tb/tb_zx81_keymatrix.sv
// Directed bench for zx81_keymatrix with a short hold time.
module tb_zx81_keymatrix;

    localparam int unsigned HOLD = 1000;
    localparam int unsigned TW   = 10;

    logic        clk_sys = 1'b0;
    logic        reset_n = 1'b0;
    logic [10:0] ps2_key = 11'h400;
    logic [7:0]  addr_hi = 8'hFF;
    logic [4:0]  kb_col;
    logic        key_reset;

    int n_total = 0;
    int n_bad   = 0;

    always #5 clk_sys = ~clk_sys;

    zx81_keymatrix #(
        .MIN_HOLD (HOLD),
        .TW       (TW)
    ) dut (
        .clk_sys   (clk_sys),
        .reset_n   (reset_n),
        .ps2_key   (ps2_key),
        .addr_hi   (addr_hi),
        .kb_col    (kb_col),
        .key_reset (key_reset)
    );

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic wait_n(input int n);
        repeat (n) @(negedge clk_sys);
    endtask

    task automatic rd(input string tag, input logic [7:0] addr, input logic [4:0] exp);
        addr_hi = addr;
        #1;
        check(tag, {3'b000, kb_col}, {3'b000, exp});
    endtask

    // Drive one event on a falling edge. The new state is visible two falling
    // edges later.
    task automatic send(input logic e0, input logic [7:0] code, input logic make);
        @(negedge clk_sys);
        ps2_key = {~ps2_key[10], make, e0, code};
        wait_n(2);
    endtask

    initial begin
        // Reset with the toggle bit high.
        wait_n(3);
        rd("rst_00", 8'h00, 5'h1F);
        rd("rst_fe", 8'hFE, 5'h1F);
        check("rst_kr", {7'b0, key_reset}, 8'h00);
        @(negedge clk_sys);
        reset_n = 1'b1;
        wait_n(4);
        rd("prime_00", 8'h00, 5'h1F);
        check("prime_kr", {7'b0, key_reset}, 8'h00);

        // Make Z, checking the two-cycle latency.
        @(negedge clk_sys);
        ps2_key = {~ps2_key[10], 1'b1, 1'b0, 8'h1A};
        @(negedge clk_sys);
        rd("z_lat1", 8'hFE, 5'h1F);
        @(negedge clk_sys);
        rd("z_lat2", 8'hFE, 5'h1D);
        rd("z_row1", 8'hFD, 5'h1F);
        wait_n(HOLD + 5);
        send(1'b0, 8'h1A, 1'b0);
        rd("z_brk", 8'hFE, 5'h1F);

        // P: make at k=0, break at k~100. P stays down through k=999.
        send(1'b0, 8'h4D, 1'b1);
        rd("p_mk", 8'hDF, 5'h1E);
        wait_n(99);
        send(1'b0, 8'h4D, 1'b0);
        rd("p_brk", 8'hDF, 5'h1E);
        wait_n(897);
        rd("p_999", 8'hDF, 5'h1E);
        wait_n(1);
        rd("p_1000", 8'hDF, 5'h1F);

        // Backspace gives SHIFT+0. A physical SHIFT outlives the compound key.
        send(1'b0, 8'h66, 1'b1);
        rd("bs_fe", 8'hFE, 5'h1E);
        rd("bs_ef", 8'hEF, 5'h1E);
        send(1'b0, 8'h12, 1'b1);
        send(1'b0, 8'h66, 1'b0);
        rd("bs_pend", 8'hEF, 5'h1E);
        wait_n(HOLD + 5);
        rd("bs_shl", 8'hFE, 5'h1E);
        rd("bs_rel", 8'hEF, 5'h1F);
        send(1'b0, 8'h12, 1'b0);
        rd("shl_rel", 8'hFE, 5'h1F);

        // Cursor left (SHIFT+5) and up (SHIFT+7) together.
        send(1'b1, 8'h6B, 1'b1);
        send(1'b1, 8'h75, 1'b1);
        rd("cur_all", 8'h00, 5'h06);
        rd("cur_r0", 8'hFE, 5'h1E);
        rd("cur_r3", 8'hF7, 5'h0F);
        rd("cur_r4", 8'hEF, 5'h17);
        send(1'b1, 8'h6B, 1'b0);
        wait_n(HOLD + 5);
        rd("cur_shift", 8'hFE, 5'h1E);
        rd("cur_r3b", 8'hF7, 5'h1F);
        rd("cur_r4b", 8'hEF, 5'h17);
        send(1'b1, 8'h75, 1'b0);
        rd("cur_none", 8'hFE, 5'h1F);

        // F12 sets key_reset. An async reset while keys are held clears everything.
        send(1'b0, 8'h07, 1'b1);
        check("f12_kr", {7'b0, key_reset}, 8'h01);
        send(1'b0, 8'h1A, 1'b1);
        rd("z2_mk", 8'hFE, 5'h1D);
        @(negedge clk_sys);
        reset_n = 1'b0;
        #1;
        rd("ar_col", 8'h00, 5'h1F);
        check("ar_kr", {7'b0, key_reset}, 8'h00);
        wait_n(2);
        @(negedge clk_sys);
        reset_n = 1'b1;
        wait_n(4);
        rd("ar_noevt", 8'h00, 5'h1F);
        check("ar_kr2", {7'b0, key_reset}, 8'h00);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
